mat_mult_host: RTL and testbench

Host-side sequencer for the 6x6 matrix-multiply core. Accepts operand matrices A then B as a stream of 27-bit words, holds them on the core's operand buses, and clears and runs the core for exactly one 10-cycle pass. It then streams the 36 result words back out. It sits between the bus/stream front end and the core, driving the core's clk/rst/en/dataa/datab and reading its result array.

---
 rtl/mat_mult_host.sv | 240 ++++++++++++++++++++++++
 tb/tb_mat_mult_host.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_host.sv
`default_nettype none
// ============================================================================
//  Module      : mat_mult_host
//  Description : Host-side sequencer for the 6x6 matrix-multiply core.
//                Collects operand matrices A then B (row-major, 72 words)
//                from an input stream and holds them on the core operand
//                buses. It then clears the core for one cycle and enables
//                it for RUN_CYCLES cycles. Finally it streams the 36 result
//                words back out with valid/ready handshaking.
//
//  Ports
//    clk          : single clock, also drives the core
//    rst_n        : asynchronous active-low reset
//    in_valid     : input word valid
//    in_ready     : block accepts input (LOAD only)
//    in_data      : operand element, W bits
//    out_valid    : result word valid (DRAIN only)
//    out_ready    : downstream accepts result
//    out_data     : result element, W bits
//    out_last     : high with result element 35
//    busy         : high in CLEAR, RUN, DRAIN
//    core_rst     : core synchronous clear, active-high
//    core_en      : core enable
//    core_dataa   : packed A operand, element k at slot N*N-1-k
//    core_datab   : packed B operand, element k at slot N*N-1-k
//    core_result  : packed core accumulators, element k at slot N*N-1-k
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mat_mult_host #(
    parameter int N          = 6,
    parameter int W          = 27,
    parameter int RUN_CYCLES = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic               out_last,
    output logic               busy,
    output logic               core_rst,
    output logic               core_en,
    output logic [N*N*W-1:0]   core_dataa,
    output logic [N*N*W-1:0]   core_datab,
    input  logic [N*N*W-1:0]   core_result
);

    localparam int c_num_el  = N * N;
    localparam int c_num_ld  = 2 * c_num_el;
    localparam int c_ld_w    = $clog2(c_num_ld);
    localparam int c_slot_w  = $clog2(c_num_el);
    localparam int c_run_w   = $clog2(RUN_CYCLES);

    localparam logic [c_ld_w-1:0]   c_ld_last  = c_ld_w'(c_num_ld - 1);
    localparam logic [c_ld_w-1:0]   c_ld_b_base = c_ld_w'(c_num_el);
    localparam logic [c_slot_w-1:0] c_rd_last  = c_slot_w'(c_num_el - 1);
    localparam logic [c_run_w-1:0]  c_run_last = c_run_w'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_ld_w-1:0]     r_ld;
    logic [c_run_w-1:0]    r_run_cnt;
    logic [c_slot_w-1:0]   r_rd;
    logic [W-1:0]          r_opa [c_num_el];
    logic [W-1:0]          r_opb [c_num_el];

    logic                  w_accept;
    logic                  w_out_hs;
    logic                  w_ld_is_b;
    logic [c_slot_w-1:0]   w_slot;
    logic [W-1:0]          w_out_sel;

    // ------------------------------------------------------------------------
    // Handshakes and load-slot decode
    // ------------------------------------------------------------------------
    assign w_accept  = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;
    assign w_ld_is_b = (r_ld >= c_ld_b_base);

    always_comb begin
        w_slot = '0;
        if (w_ld_is_b) begin
            w_slot = c_slot_w'(r_ld - c_ld_b_base);
        end else begin
            w_slot = c_slot_w'(r_ld);
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        core_en     = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept && (r_ld == c_ld_last)) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                core_en = 1'b1;
                if (r_run_cnt == c_run_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (w_out_hs && (r_rd == c_rd_last)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // The core is held in clear for as long as this block is in reset, so a
    // mid-pass abort never leaves stale partial sums behind.
    assign core_rst = (r_state == S_CLEAR) | ~rst_n;
    assign out_last = (r_state == S_DRAIN) && (r_rd == c_rd_last);

    // ------------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld <= '0;
        end else if ((r_state == S_LOAD) && w_accept) begin
            if (r_ld == c_ld_last) begin
                r_ld <= '0;
            end else begin
                r_ld <= r_ld + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt <= '0;
        end else if (r_state == S_RUN) begin
            if (r_run_cnt == c_run_last) begin
                r_run_cnt <= '0;
            end else begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end
        end else begin
            r_run_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd <= '0;
        end else if ((r_state == S_DRAIN) && w_out_hs) begin
            if (r_rd == c_rd_last) begin
                r_rd <= '0;
            end else begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Operand storage: written only on LOAD accepts, so values stay frozen
    // through CLEAR, RUN and DRAIN and persist until the next job overwrites.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < c_num_el; k++) begin
                r_opa[k] <= '0;
                r_opb[k] <= '0;
            end
        end else if ((r_state == S_LOAD) && w_accept) begin
            for (int k = 0; k < c_num_el; k++) begin
                if (w_slot == c_slot_w'(k)) begin
                    if (w_ld_is_b) begin
                        r_opb[k] <= in_data;
                    end else begin
                        r_opa[k] <= in_data;
                    end
                end
            end
        end
    end

    // Element k occupies the slot counted down from the top of the bus.
    for (genvar k = 0; k < c_num_el; k++) begin : g_pack
        assign core_dataa[(c_num_el-1-k)*W +: W] = r_opa[k];
        assign core_datab[(c_num_el-1-k)*W +: W] = r_opb[k];
    end

    // ------------------------------------------------------------------------
    // Result read-out: rd selects element rd, i.e. slot N*N-1-rd. The core is
    // disabled during DRAIN, so the selected word is stable across stalls.
    // ------------------------------------------------------------------------
    always_comb begin
        w_out_sel = '0;
        for (int k = 0; k < c_num_el; k++) begin
            if (r_rd == c_slot_w'(k)) begin
                w_out_sel = core_result[(c_num_el-1-k)*W +: W];
            end
        end
    end

    assign out_data = w_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_mat_mult_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mat_mult_host
//  Description : Self-checking bench for mat_mult_host. Contains a simple
//                behavioural matrix core and a plain-arithmetic reference
//                product used to predict every streamed result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_mult_host;

    localparam int N          = 6;
    localparam int W          = 27;
    localparam int RUN_CYCLES = 10;
    localparam int NE         = N * N;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [W-1:0]      out_data;
    logic              out_last;
    logic              busy;
    logic              core_rst;
    logic              core_en;
    logic [NE*W-1:0]   core_dataa;
    logic [NE*W-1:0]   core_datab;
    logic [NE*W-1:0]   core_result;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] ma    [NE];
    logic [W-1:0] mb    [NE];
    logic [W-1:0] exp_c [NE];

    mat_mult_host #(.N(N), .W(W), .RUN_CYCLES(RUN_CYCLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .core_rst    (core_rst),
        .core_en     (core_en),
        .core_dataa  (core_dataa),
        .core_datab  (core_datab),
        .core_result (core_result)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Behavioural core: phases 0..N-1 of each RUN_CYCLES-long pass add one
    // rank-1 term A[:,p]*B[p,:]; the remaining phases idle.
    // ------------------------------------------------------------------------
    logic [W-1:0] acc [NE];
    int           phase;

    function automatic logic [W-1:0] ga(input int k);
        return core_dataa[(NE-1-k)*W +: W];
    endfunction

    function automatic logic [W-1:0] gb(input int k);
        return core_datab[(NE-1-k)*W +: W];
    endfunction

    always @(posedge clk) begin
        if (core_rst) begin
            for (int k = 0; k < NE; k++) acc[k] <= '0;
            phase <= 0;
        end else if (core_en) begin
            if (phase < N) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        acc[i*N+j] <= acc[i*N+j] +
                            W'(longint'(ga(i*N+phase)) * longint'(gb(phase*N+j)));
            end
            phase <= (phase == RUN_CYCLES-1) ? 0 : phase + 1;
        end
    end

    always_comb begin
        core_result = '0;
        for (int k = 0; k < NE; k++) core_result[(NE-1-k)*W +: W] = acc[k];
    end

    // ------------------------------------------------------------------------
    // Reference product C = A*B mod 2^W, straight from the definition.
    // ------------------------------------------------------------------------
    function automatic void ref_mult();
        longint unsigned s;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int t = 0; t < N; t++)
                    s += longint'(ma[i*N+t]) * longint'(mb[t*N+j]);
                exp_c[i*N+j] = W'(s);
            end
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Streams A then B; gap_pct percent of cycles randomly drop in_valid.
    // Returns just after the 72nd accepting edge (E0).
    task automatic load_job(input string tag, input int gap_pct);
        int k = 0;
        int guard = 0;
        ref_mult();
        while (k < 2*NE && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = (k < NE) ? ma[k] : mb[k-NE];
                if (in_ready) k++;
            end
        end
        check({tag, " words accepted"}, k, 2*NE);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for results, then drains all 36 with low_pct percent stalls.
    // Random in_valid traffic during processing must be ignored.
    task automatic drain_job(input string tag, input int low_pct);
        int n = 0;
        int idx = 0;
        int guard = 0;
        int bad_win = 0;
        int bad_stall = 0;
        bit prev_stall = 1'b0;
        logic [W-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad_win++;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " first out_valid latency"}, n, 11);
        while (idx < NE && guard < 2000) begin
            @(negedge clk);
            guard++;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 99) >= low_pct);
            if (prev_stall && (out_data !== prev_data || out_last !== prev_last)) bad_stall++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) bad_win++;
            if (out_valid && out_ready) begin
                check($sformatf("%s data[%0d]", tag, idx), out_data, exp_c[idx]);
                check($sformatf("%s last[%0d]", tag, idx), out_last, (idx == NE-1));
                idx++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = out_valid;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
        check({tag, " words drained"}, idx, NE);
        check({tag, " busy/in_ready window"}, bad_win, 0);
        check({tag, " stall stability"}, bad_stall, 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, " in_ready after drain"}, in_ready, 1);
        check({tag, " busy after drain"}, busy, 0);
        check({tag, " out_valid after drain"}, out_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst out_last", out_last, 0);
        check("rst busy", busy, 0);
        check("rst core_en", core_en, 0);
        check("rst core_rst", core_rst, 1);
        check("rst dataa", core_dataa, 0);
        check("rst out_data", out_data, 0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("post-rst core_rst", core_rst, 0);

        // ---------------- identity x (k+1) ----------------
        for (int k = 0; k < NE; k++) begin
            ma[k] = (k / N == k % N) ? W'(1) : W'(0);
            mb[k] = W'(k + 1);
        end
        load_job("ident", 0);
        drain_job("ident", 0);

        // ---------------- all ones ----------------
        for (int k = 0; k < NE; k++) begin ma[k] = W'(1); mb[k] = W'(1); end
        load_job("ones", 0);
        drain_job("ones", 0);

        // ---------------- 2^26 x identity, then all 2^26 ----------------
        for (int k = 0; k < NE; k++) begin
            ma[k] = W'(1) << 26;
            mb[k] = (k / N == k % N) ? W'(1) : W'(0);
        end
        load_job("big_id", 0);
        drain_job("big_id", 0);
        for (int k = 0; k < NE; k++) begin ma[k] = W'(1) << 26; mb[k] = W'(1) << 26; end
        load_job("big_wrap", 0);
        drain_job("big_wrap", 0);

        // ---------------- A[k]=k, identity, random backpressure ----------------
        for (int k = 0; k < NE; k++) begin
            ma[k] = W'(k);
            mb[k] = (k / N == k % N) ? W'(1) : W'(0);
        end
        load_job("bp", 0);
        drain_job("bp", 30);

        // ---------------- fully random operands and backpressure ----------------
        for (int k = 0; k < NE; k++) begin ma[k] = W'($urandom); mb[k] = W'($urandom); end
        load_job("rand", 20);
        drain_job("rand", 30);

        // ---------------- reset during RUN ----------------
        for (int k = 0; k < NE; k++) begin
            ma[k] = (k / N == k % N) ? W'(1) : W'(0);
            mb[k] = W'(k + 7);
        end
        load_job("abort", 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort in RUN core_en", core_en, 1);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", in_ready, 1);
        check("abort busy", busy, 0);
        check("abort core_en", core_en, 0);
        check("abort core_rst", core_rst, 1);
        check("abort out_valid", out_valid, 0);
        check("abort dataa cleared", core_dataa, 0);
        check("abort out_data slot35", out_data, acc[0]);
        repeat (3) @(posedge clk);
        #1;
        check("abort core cleared", out_data, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < NE; k++) begin
            ma[k] = (k / N == k % N) ? W'(1) : W'(0);
            mb[k] = W'(100 + k);
        end
        load_job("post_abort", 0);
        drain_job("post_abort", 0);

        // ---------------- back-to-back jobs ----------------
        for (int k = 0; k < NE; k++) begin ma[k] = W'($urandom); mb[k] = W'($urandom); end
        load_job("b2b_1", 0);
        drain_job("b2b_1", 0);
        for (int k = 0; k < NE; k++) begin
            ma[k] = (k / N == k % N) ? W'(2) : W'(0);
            mb[k] = W'(k);
        end
        load_job("b2b_2", 30);
        drain_job("b2b_2", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
